dmem_lsu: RTL

//  Load/store initiator between the CPU memory stage and the data memory (DMEM).
//  - Converts byte/half/word requests into word address, byte-lane write enables and lane-replicated write data.
//  - Aligns and sign/zero-extends the registered DMEM read data.
//  - Returns the load result through a valid/ready response port.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_load_align.sv | 31 +++
 rtl/dmem_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the DMEM load/store unit: access-size codes, FSM
// state encodings and the alignment check used when misalignment trapping is on.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } lsu_state_e;

  // True when the access cannot be served as a single naturally aligned lane.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of a DMEM word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  lsu_size_e   size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_shifted;

  assign word_shifted = word_i >> {addr_lo_i, 3'b000};
  assign byte_lane    = word_shifted[7:0];
  assign half_lane    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    // NOTE: every path assigns result_o, so this block stays purely combinational (no latch).
    result_o = word_i;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: result_o = {{16{signed_i & half_lane[15]}}, half_lane};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the CPU memory stage and DMEM.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata_sel,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e      state_q;
  logic [1:0]      addr_lo_q;
  lsu_size_e       size_q;
  logic            signed_q;
  logic            resp_valid_q;
  logic            resp_fault_q;
  logic [31:0]     resp_rdata_q;
  logic [TAG_W-1:0] resp_tag_q;

  lsu_size_e   req_size_e;
  logic        accept;
  logic        fault;
  logic [31:0] load_data;

  assign req_size_e = lsu_size_e'(req_size);

  // Gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault = is_misaligned(req_size_e, req_addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  assign mem_we   = accept & req_we & ~fault;
  assign mem_addr = {req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    mem_wdata_sel = 4'b1111;
    mem_wdata     = req_wdata;
    case (req_size_e)
      SZ_BYTE: begin
        mem_wdata_sel = 4'b0001 << req_addr[1:0];
        mem_wdata     = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        mem_wdata_sel = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata     = {2{req_wdata[15:0]}};
      end
      default: begin
        mem_wdata_sel = 4'b1111;
        mem_wdata     = req_wdata;
      end
    endcase
  end

  lsu_load_align u_align (
    .word_i    (mem_rdata),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .result_o  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= ST_IDLE;
      addr_lo_q    <= 2'b00;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (fault) begin
              // Trapped accesses skip the read and report straight away.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_tag_q   <= req_tag;
            end else if (!req_we) begin
              state_q    <= ST_RD_WAIT;
              addr_lo_q  <= req_addr[1:0];
              size_q     <= req_size_e;
              signed_q   <= req_signed;
              resp_tag_q <= req_tag;
            end
          end
        end
        ST_RD_WAIT: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= load_data;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;

endmodule
